imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Boot-time writer for the CPU instruction ROM. Accepts a byte stream (valid/ready), assembles
//  little-endian 32-bit instruction words and writes them to sequential ROM addresses from 0.
//  Holds the core in reset until the full program is loaded, then releases it. Sits between
//  the host/UART byte source and the instruct_reg write port; drives cpu rst.
// PARAMETERS
//  XLEN       32  instruction word width; fixed at 32 (4 bytes per word)
//  ADDR_SIZE  5   ROM address width; DEPTH = 2**ADDR_SIZE words
// PORTS
//  clk        in   1          system clock
//  rst        in   1          synchronous, active-high reset
//  in_valid   in   1          input byte valid
//  in_data    in   8          input byte
//  in_ready   out  1          loader can accept a byte
//  wr_en      out  1          ROM write strobe, one cycle per word
//  wr_addr    out  ADDR_SIZE  ROM word address
//  wr_data    out  XLEN       ROM word data
//  cpu_rst    out  1          reset to CPU core; high until load completes
//  load_done  out  1          program loaded, CPU released
//  load_err   out  1          stream rejected
// BEHAVIOUR
//  - Byte accepted on posedge where in_valid && in_ready. in_ready is a function of state only.
//  - Reset values: in_ready=0 while rst high, wr_en=0, wr_addr=0, wr_data=0, cpu_rst=1,
//    load_done=0, load_err=0. First cycle after rst low: state IDLE, in_ready=1.
//  - Stream format: byte0 = N (word count), then 4*N bytes, LSB first (first byte -> [7:0]).
//  - States: IDLE -> WORDS -> [CSUM] -> DONE; any -> ERROR; exit DONE/ERROR only via rst.
//  - IDLE: in_ready=1. Length byte: N==0 or N>DEPTH -> ERROR; else WORDS, word index=0.
//  - WORDS: in_ready=1 every cycle, no backpressure. On 4th byte of a word accepted at cycle T:
//    wr_en=1, wr_addr=index, wr_data=word in T+1 (registered, latency 1); index increments.
//  - wr_en never asserted outside WORDS write cycles; wr_addr/wr_data hold last value otherwise.
//  - Final word accepted at T (macro off): final wr_en in T+1; DONE from T+1 (in_ready=0);
//    cpu_rst=0 and load_done=1 from T+2, so CPU exits reset after final ROM write commits.
//  - in_valid gaps anywhere: no effect beyond stalling; partial word is held.
//  - N==DEPTH: last write at addr DEPTH-1; index does not wrap into another write.
//  - DONE/ERROR: in_ready=0; further in_valid ignored. ERROR: load_err=1, cpu_rst=1, load_done=0.
//  - rst mid-load: partial word discarded, back to IDLE, cpu_rst=1; already-written ROM
//    contents are not cleared (next load overwrites from addr 0).
// CONFIGURATION
//  IMEM_LOADER_CHECKSUM_EN defined: after the last word, state CSUM (in_ready=1) takes one
//   extra byte = XOR of all 4*N payload bytes (length byte excluded). Accepted at cycle T:
//   match -> DONE entered T+1, cpu_rst=0/load_done=1 from T+1; mismatch -> ERROR at T+1,
//   cpu_rst stays 1. ROM writes already issued are not undone.
//  Not defined: no CSUM state; stream ends with the last payload byte as described above.
// TESTING
//  1 Bytes 02,78,56,34,12,EF,BE,AD,DE -> wr_en addr0=0x12345678, addr1=0xDEADBEEF;
//    exactly 2 strobes; load_done=1, cpu_rst=0 one cycle after 2nd strobe.
//  2 Length 0x21 (ADDR_SIZE=5) and separately 0x00 -> load_err=1, no wr_en, in_ready=0, cpu_rst=1.
//  3 Test 1 with random 0-3 idle cycles between bytes -> identical writes, no extra strobes.
//  4 Bytes 01,11,22 then rst pulse, then 01,DD,CC,BB,AA -> single write addr0=0xAABBCCDD.
//  5 32-word load -> last write addr 31; extra bytes after DONE ignored, in_ready=0.
//  6 CHECKSUM_EN: 01,01,02,03,04,04 -> done, cpu_rst=0; same with trailing 05 -> load_err=1,
//    cpu_rst=1 (word still written to addr0).

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream input and ROM write-port bundle for imem_loader.
// master: host side (drives bytes, observes ROM writes); slave: the loader itself.
interface imem_loader_if #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ADDR_SIZE = 5
);
    logic                 in_valid;
    logic [7:0]           in_data;
    logic                 in_ready;
    logic                 wr_en;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [XLEN-1:0]      wr_data;
    logic                 cpu_rst;
    logic                 load_done;
    logic                 load_err;

    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data, cpu_rst, load_done, load_err
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data, cpu_rst, load_done, load_err
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction ROM loader: length byte, then N little-endian words written from addr 0.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before releasing the CPU.
module imem_loader #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ADDR_SIZE = 5
) (
    input logic          clk,
    input logic          rst,
    imem_loader_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_SIZE;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StWords = 3'd1,
        StDone  = 3'd2,
        StError = 3'd3
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        StCsum  = 3'd4
`endif
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           byte_cnt_q, byte_cnt_d;
    logic [ADDR_SIZE-1:0] idx_q, idx_d;
    logic [ADDR_SIZE-1:0] last_idx_q, last_idx_d;
    logic [23:0]          part_q, part_d;
    logic                 wr_en_q, wr_en_d;
    logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
    logic [XLEN-1:0]      wr_data_q, wr_data_d;
    logic                 done_q, done_d;
    logic [7:0]           csum_q, csum_d;
    logic                 in_ready;
    logic                 accept;

    // Gated by rst so the source sees no readiness while the loader is held in reset.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            unique case (state_q)
                StIdle, StWords: in_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                StCsum:          in_ready = 1'b1;
`endif
                default:         in_ready = 1'b0;
            endcase
        end
    end

    assign accept = bus.in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        idx_d      = idx_q;
        last_idx_d = last_idx_q;
        part_d     = part_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        csum_d     = csum_q;
        done_d     = done_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (bus.in_data == 8'd0 || {24'd0, bus.in_data} > DEPTH) begin
                        state_d = StError;
                    end else begin
                        state_d    = StWords;
                        idx_d      = '0;
                        byte_cnt_d = 2'd0;
                        last_idx_d = ADDR_SIZE'(bus.in_data - 8'd1);
                        csum_d     = 8'd0;
                    end
                end
            end
            StWords: begin
                if (accept) begin
                    csum_d     = csum_q ^ bus.in_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    unique case (byte_cnt_q)
                        2'd0: part_d[7:0]   = bus.in_data;
                        2'd1: part_d[15:8]  = bus.in_data;
                        2'd2: part_d[23:16] = bus.in_data;
                        default: begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = idx_q;
                            wr_data_d = XLEN'({bus.in_data, part_q});
                            // Stop at the last word rather than letting the index wrap.
                            if (idx_q == last_idx_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state_d = StCsum;
`else
                                state_d = StDone;
`endif
                            end else begin
                                idx_d = idx_q + 1'b1;
                            end
                        end
                    endcase
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            StCsum: begin
                if (accept) begin
                    if (bus.in_data == csum_q) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StError;
                    end
                end
            end
`endif
            default: ;
        endcase

`ifndef IMEM_LOADER_CHECKSUM_EN
        // Release one cycle after DONE so the final ROM write commits first.
        if (state_q == StDone) done_d = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            byte_cnt_q <= 2'd0;
            idx_q      <= '0;
            last_idx_q <= '0;
            part_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            csum_q     <= 8'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            idx_q      <= idx_d;
            last_idx_q <= last_idx_d;
            part_q     <= part_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            csum_q     <= csum_d;
            done_q     <= done_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.cpu_rst   = !done_q;
    assign bus.load_done = done_q;
    assign bus.load_err  = (state_q == StError);
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal loads, bad lengths, gaps, mid-load reset, full depth.
module tb_imem_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   wr_cnt = 0;
    int   base;
    logic [4:0]  log_addr [0:127];
    logic [31:0] log_data [0:127];
    logic [7:0]  tb_x;

    imem_loader_if #(.XLEN(32), .ADDR_SIZE(5)) bus ();

    imem_loader #(.XLEN(32), .ADDR_SIZE(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.wr_en) begin
            if (wr_cnt < 128) begin
                log_addr[wr_cnt] = bus.wr_addr;
                log_data[wr_cnt] = bus.wr_data;
            end
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp)
        else begin
            bad = bad + 1;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
        chk("rst_cpu_rst", {31'd0, bus.cpu_rst}, 32'd1);
        chk("rst_done_err", {30'd0, bus.load_done, bus.load_err}, 32'd0);
        chk("rst_wr_addr_data", bus.wr_data | {27'd0, bus.wr_addr}, 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        tb_x = tb_x ^ b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_len(input logic [7:0] n);
        send(n, 0);
        tb_x = 8'd0;
    endtask

    task automatic send_csum();
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(tb_x, 0);
`endif
    endtask

    task automatic run_test1(input bit gaps);
        logic [7:0] bytes [0:7];
        bytes = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        base = wr_cnt;
        send_len(8'h02);
        for (int i = 0; i < 8; i++) send(bytes[i], gaps ? int'($urandom_range(0, 3)) : 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("t1_csum_ready", {31'd0, bus.in_ready}, 32'd1);
        send_csum();
        chk("t1_done", {30'd0, bus.load_done, bus.cpu_rst}, 32'd2);
`else
        if (!gaps) begin
            chk("t1_ready_after_last", {31'd0, bus.in_ready}, 32'd0);
            chk("t1_not_yet_done", {30'd0, bus.load_done, bus.cpu_rst}, 32'd1);
        end
        @(posedge clk);
        #1;
        chk("t1_done", {30'd0, bus.load_done, bus.cpu_rst}, 32'd2);
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("t1_strobes", wr_cnt - base, 32'd2);
        chk("t1_addr0", {27'd0, log_addr[base]}, 32'd0);
        chk("t1_data0", log_data[base], 32'h12345678);
        chk("t1_addr1", {27'd0, log_addr[base+1]}, 32'd1);
        chk("t1_data1", log_data[base+1], 32'hDEADBEEF);
    endtask

    task automatic check_err(input string tag);
        chk({tag, "_err"}, {31'd0, bus.load_err}, 32'd1);
        chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
        chk({tag, "_cpu_rst"}, {30'd0, bus.cpu_rst, bus.load_done}, 32'd2);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        tb_x = 8'd0;

        // Test 1: two-word load
        do_reset();
        run_test1(1'b0);

        // Test 2: oversize and zero length
        do_reset();
        base = wr_cnt;
        send_len(8'h21);
        check_err("t2_big");
        send(8'h01, 0);
        send(8'h02, 3);
        check_err("t2_big_after");
        chk("t2_big_no_wr", wr_cnt - base, 32'd0);
        do_reset();
        base = wr_cnt;
        send_len(8'h00);
        send(8'h55, 3);
        check_err("t2_zero");
        chk("t2_zero_no_wr", wr_cnt - base, 32'd0);

        // Test 3: test 1 with random idle gaps
        do_reset();
        run_test1(1'b1);

        // Test 4: reset mid-load discards the partial word
        do_reset();
        send_len(8'h01);
        send(8'h11, 0);
        send(8'h22, 0);
        do_reset();
        base = wr_cnt;
        send_len(8'h01);
        send(8'hDD, 0);
        send(8'hCC, 0);
        send(8'hBB, 0);
        send(8'hAA, 0);
        send_csum();
        repeat (3) @(posedge clk);
        #1;
        chk("t4_strobes", wr_cnt - base, 32'd1);
        chk("t4_addr", {27'd0, log_addr[base]}, 32'd0);
        chk("t4_data", log_data[base], 32'hAABBCCDD);
        chk("t4_done", {30'd0, bus.load_done, bus.cpu_rst}, 32'd2);

        // Test 5: full-depth load, trailing bytes ignored
        do_reset();
        base = wr_cnt;
        send_len(8'h20);
        for (int i = 0; i < 128; i++) send(8'(i), 0);
        send_csum();
        repeat (2) @(posedge clk);
        #1;
        chk("t5_done", {30'd0, bus.load_done, bus.cpu_rst}, 32'd2);
        send(8'hA5, 0);
        send(8'h5A, 0);
        send(8'hFF, 2);
        chk("t5_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("t5_strobes", wr_cnt - base, 32'd32);
        chk("t5_first", log_data[base], 32'h03020100);
        chk("t5_last_addr", {27'd0, log_addr[base+31]}, 32'd31);
        chk("t5_last_data", log_data[base+31], 32'h7F7E7D7C);
        chk("t5_still_done", {30'd0, bus.load_done, bus.load_err}, 32'd2);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Test 6: checksum match and mismatch
        do_reset();
        base = wr_cnt;
        send_len(8'h01);
        send(8'h01, 0);
        send(8'h02, 0);
        send(8'h03, 0);
        send(8'h04, 0);
        send(8'h04, 0);
        chk("t6_ok_done", {29'd0, bus.load_done, bus.cpu_rst, bus.load_err}, 32'd4);
        do_reset();
        send_len(8'h01);
        send(8'h01, 0);
        send(8'h02, 0);
        send(8'h03, 0);
        send(8'h04, 0);
        send(8'h05, 0);
        check_err("t6_bad");
        repeat (2) @(posedge clk);
        #1;
        chk("t6_strobes", wr_cnt - base, 32'd2);
        chk("t6_data", log_data[base+1], 32'h04030201);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
